// File: rtl/reg_scoreboard_pkg.sv
// Shared CPU pipeline parameters.
// Register-address and scoreboard counter widths.
package reg_scoreboard_pkg;
  localparam int PIPE_REG_W = 3;
  localparam int SB_REG_W   = PIPE_REG_W;
  localparam int SB_CNT_W   = 2;
  localparam int SB_CMAX    = (1 << SB_CNT_W) - 1;
endpackage

// File: rtl/reg_pend_cnt.sv
// Pending-write counter for one architectural register.
// nz is registered from the next count, so it tracks count exactly.
module reg_pend_cnt
  import reg_scoreboard_pkg::*;
#(
  parameter int CNT_W = SB_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  input  logic             clr,
  output logic [CNT_W-1:0] count,
  output logic             nz
);

  logic [CNT_W-1:0] nxt;

  // Next count: clear wins, inc and dec together cancel
  always_comb begin
    nxt = count;
    if (clr)
      nxt = '0;
    else if (inc && !dec)
      nxt = count + CNT_W'(1);
    else if (dec && !inc)
      nxt = count - CNT_W'(1);
  end

  // Counter and its non-zero view
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      nz    <= 1'b0;
    end else begin
      count <= nxt;
      nz    <= |nxt;
    end
  end

endmodule

// File: rtl/reg_scoreboard.sv
// Register scoreboard: RAW/WAW hazard check, writeback forwarding,
// per-register pending-write counters and stall statistics.
module reg_scoreboard
  import reg_scoreboard_pkg::*;
#(
  parameter int REG_W = SB_REG_W,
  parameter int CNT_W = SB_CNT_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  issue_valid,
  input  logic                  issue_rw,
  input  logic [REG_W-1:0]      issue_rd,
  input  logic [REG_W-1:0]      issue_rs1,
  input  logic [REG_W-1:0]      issue_rs2,
  input  logic                  issue_rs1_used,
  input  logic                  issue_rs2_used,
  output logic                  issue_ready,
  output logic                  fwd_rs1,
  output logic                  fwd_rs2,
  input  logic                  wb_valid,
  input  logic [REG_W-1:0]      wb_rd,
  input  logic                  flush,
  output logic [(1<<REG_W)-1:0] busy,
  output logic                  wb_err,
  output logic [15:0]           stall_cycles
);

  localparam int NREG = 1 << REG_W;
  localparam logic [CNT_W-1:0] CMAX = '1;
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  logic [CNT_W-1:0] cnt [NREG];
  logic [NREG-1:0]  nz;
  logic [NREG-1:0]  wb_hit;
  logic [NREG-1:0]  inc;
  logic [NREG-1:0]  dec;
  logic last1, last2, raw1, raw2, waw;
  logic issue_fire;

  // Hazard detection against pre-issue counters
  always_comb begin
    last1 = wb_hit[issue_rs1] && (cnt[issue_rs1] == ONE);
    last2 = wb_hit[issue_rs2] && (cnt[issue_rs2] == ONE);
    raw1  = issue_rs1_used && nz[issue_rs1] && !last1;
    raw2  = issue_rs2_used && nz[issue_rs2] && !last2;
    waw   = issue_rw && (cnt[issue_rd] == CMAX)
            && !wb_hit[issue_rd];
  end

  assign issue_ready = !(raw1 || raw2 || waw) && !flush;
  assign issue_fire  = issue_valid && issue_ready;
  assign fwd_rs1     = issue_rs1_used && last1;
  assign fwd_rs2     = issue_rs2_used && last2;

  // Per-register increment/decrement requests
  always_comb begin
    wb_hit = '0;
    inc    = '0;
    dec    = '0;
    for (int r = 0; r < NREG; r++) begin
      wb_hit[r] = wb_valid && (wb_rd == REG_W'(r));
      inc[r]    = issue_fire && issue_rw
                  && (issue_rd == REG_W'(r));
      dec[r]    = wb_hit[r] && nz[r];
    end
  end

  genvar g;
  for (g = 0; g < NREG; g++) begin : g_cnt
    reg_pend_cnt #(.CNT_W(CNT_W)) u_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (inc[g]),
      .dec   (dec[g]),
      .clr   (flush),
      .count (cnt[g]),
      .nz    (nz[g])
    );
  end

  assign busy = nz;

  // Sticky flag for writebacks with nothing pending
  always_ff @(posedge clk) begin
    if (rst)
      wb_err <= 1'b0;
    else if (wb_valid && !nz[wb_rd])
      wb_err <= 1'b1;
  end

  // Saturating count of stalled issue cycles
  always_ff @(posedge clk) begin
    if (rst)
      stall_cycles <= '0;
    else if (issue_valid && !issue_ready
             && (stall_cycles != 16'hFFFF))
      stall_cycles <= stall_cycles + 16'd1;
  end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard against a
// spec-level model of pending writes per register.
module tb_reg_scoreboard;

  localparam int NREG = 8;
  localparam int CMAX = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       iv, irw, iu1, iu2;
  logic [2:0] ird, irs1, irs2;
  logic       wv;
  logic [2:0] wrd;
  logic       fl;
  logic       ready, fwd1, fwd2;
  logic [7:0] busy;
  logic       werr;
  logic [15:0] stall;

  int errors = 0;
  int checks = 0;

  int mc [NREG];
  bit merr;
  int mstall;

  logic obs_ready, obs_fwd1, obs_fwd2;

  always #5 clk = ~clk;

  reg_scoreboard dut (
    .clk            (clk),
    .rst            (rst),
    .issue_valid    (iv),
    .issue_rw       (irw),
    .issue_rd       (ird),
    .issue_rs1      (irs1),
    .issue_rs2      (irs2),
    .issue_rs1_used (iu1),
    .issue_rs2_used (iu2),
    .issue_ready    (ready),
    .fwd_rs1        (fwd1),
    .fwd_rs2        (fwd2),
    .wb_valid       (wv),
    .wb_rd          (wrd),
    .flush          (fl),
    .busy           (busy),
    .wb_err         (werr),
    .stall_cycles   (stall)
  );

  task automatic idle();
    rst = 0; iv = 0; irw = 0; iu1 = 0; iu2 = 0;
    ird = 0; irs1 = 0; irs2 = 0;
    wv = 0; wrd = 0; fl = 0;
  endtask

  function automatic logic [7:0] mbusy();
    logic [7:0] b;
    for (int r = 0; r < NREG; r++) b[r] = (mc[r] != 0);
    return b;
  endfunction

  // One clock: check combinational outputs, advance model,
  // check registered outputs.
  task automatic step(input bit chk);
    bit hit1, hit2, hitd, l1, l2, r1, r2, w, er, ef1, ef2;
    bit fire, dodec;
    @(negedge clk);
    hit1 = wv && wrd == irs1;
    hit2 = wv && wrd == irs2;
    hitd = wv && wrd == ird;
    l1 = hit1 && mc[irs1] == 1;
    l2 = hit2 && mc[irs2] == 1;
    r1 = iu1 && mc[irs1] != 0 && !l1;
    r2 = iu2 && mc[irs2] != 0 && !l2;
    w  = irw && mc[ird] == CMAX && !hitd;
    er = !(r1 || r2 || w) && !fl;
    ef1 = iu1 && l1;
    ef2 = iu2 && l2;
    obs_ready = ready;
    obs_fwd1 = fwd1;
    obs_fwd2 = fwd2;
    if (chk) begin
      checks += 3;
      if (ready !== er) begin
        errors++;
        $display("FAIL ready: got %b want %b t=%0t",
                 ready, er, $time);
      end
      if (fwd1 !== ef1) begin
        errors++;
        $display("FAIL fwd_rs1: got %b want %b t=%0t",
                 fwd1, ef1, $time);
      end
      if (fwd2 !== ef2) begin
        errors++;
        $display("FAIL fwd_rs2: got %b want %b t=%0t",
                 fwd2, ef2, $time);
      end
    end
    @(posedge clk);
    if (rst) begin
      foreach (mc[r]) mc[r] = 0;
      merr = 0;
      mstall = 0;
    end else begin
      if (iv && !er && mstall < 65535) mstall++;
      if (wv && mc[wrd] == 0) merr = 1;
      if (fl) begin
        foreach (mc[r]) mc[r] = 0;
      end else begin
        fire  = iv && er;
        dodec = wv && mc[wrd] != 0;
        if (fire && irw) mc[ird]++;
        if (dodec) mc[wrd]--;
      end
    end
    #1;
    if (chk) begin
      checks += 3;
      if (busy !== mbusy()) begin
        errors++;
        $display("FAIL busy: got %h want %h t=%0t",
                 busy, mbusy(), $time);
      end
      if (werr !== merr) begin
        errors++;
        $display("FAIL wb_err: got %b want %b t=%0t",
                 werr, merr, $time);
      end
      if (stall !== 16'(mstall)) begin
        errors++;
        $display("FAIL stall_cycles: got %0d want %0d t=%0t",
                 stall, mstall, $time);
      end
    end
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    step(1);
    idle();
  endtask

  task automatic test_reset();
    do_reset();
    step(1);
    checks += 6;
    if (obs_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b want 1", obs_ready);
    end
    if (obs_fwd1 !== 1'b0 || obs_fwd2 !== 1'b0) begin
      errors++;
      $display("FAIL reset_fwd: got %b%b want 00",
               obs_fwd1, obs_fwd2);
    end
    if (busy !== 8'h00) begin
      errors++;
      $display("FAIL reset_busy: got %h want 00", busy);
    end
    if (werr !== 1'b0) begin
      errors++;
      $display("FAIL reset_err: got %b want 0", werr);
    end
    if (stall !== 16'd0) begin
      errors++;
      $display("FAIL reset_stall: got %0d want 0", stall);
    end
    if (ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready2: got %b want 1", ready);
    end
  endtask

  task automatic test_raw();
    do_reset();
    iv = 1; irw = 1; ird = 3;
    step(1);
    irw = 0; irs1 = 3; iu1 = 1;
    step(1);
    checks += 2;
    if (obs_ready !== 1'b0) begin
      errors++;
      $display("FAIL raw_stall: got %b want 0", obs_ready);
    end
    if (stall !== 16'd1) begin
      errors++;
      $display("FAIL raw_cnt: got %0d want 1", stall);
    end
    wv = 1; wrd = 3;
    step(1);
    checks += 3;
    if (obs_ready !== 1'b1 || obs_fwd1 !== 1'b1) begin
      errors++;
      $display("FAIL raw_fwd: got rdy=%b fwd=%b want 1 1",
               obs_ready, obs_fwd1);
    end
    if (busy[3] !== 1'b0) begin
      errors++;
      $display("FAIL raw_busy: got %b want 0", busy[3]);
    end
    if (stall !== 16'd1) begin
      errors++;
      $display("FAIL raw_cnt2: got %0d want 1", stall);
    end
    idle();
  endtask

  task automatic test_waw();
    do_reset();
    iv = 1; irw = 1; ird = 5;
    repeat (3) step(1);
    step(1);
    checks++;
    if (obs_ready !== 1'b0) begin
      errors++;
      $display("FAIL waw_sat: got %b want 0", obs_ready);
    end
    wv = 1; wrd = 5;
    step(1);
    checks += 2;
    if (obs_ready !== 1'b1) begin
      errors++;
      $display("FAIL waw_wb: got %b want 1", obs_ready);
    end
    if (busy[5] !== 1'b1) begin
      errors++;
      $display("FAIL waw_busy: got %b want 1", busy[5]);
    end
    wv = 0;
    step(1);
    checks++;
    if (obs_ready !== 1'b0) begin
      errors++;
      $display("FAIL waw_hold3: got %b want 0", obs_ready);
    end
    idle();
  endtask

  task automatic test_simul();
    do_reset();
    iv = 1; irw = 1; ird = 2;
    step(1);
    wv = 1; wrd = 2;
    step(1);
    checks += 2;
    if (obs_ready !== 1'b1) begin
      errors++;
      $display("FAIL simul_rdy: got %b want 1", obs_ready);
    end
    if (busy[2] !== 1'b1) begin
      errors++;
      $display("FAIL simul_busy: got %b want 1", busy[2]);
    end
    iv = 0; irw = 0;
    step(1);
    checks++;
    if (busy[2] !== 1'b0) begin
      errors++;
      $display("FAIL simul_one: got %b want 0", busy[2]);
    end
    idle();
  endtask

  task automatic test_spurious();
    do_reset();
    iv = 1; irw = 1; ird = 4;
    step(1);
    iv = 0; irw = 0;
    wv = 1; wrd = 7;
    step(1);
    checks += 2;
    if (werr !== 1'b1) begin
      errors++;
      $display("FAIL spur_err: got %b want 1", werr);
    end
    if (busy !== 8'h10) begin
      errors++;
      $display("FAIL spur_busy: got %h want 10", busy);
    end
    for (int i = 0; i < 20; i++) begin
      iv = 1'($urandom); irw = 1'($urandom);
      ird = 3'($urandom); irs1 = 3'($urandom);
      irs2 = 3'($urandom); iu1 = 1'($urandom);
      iu2 = 1'($urandom); wv = 1'($urandom);
      wrd = 3'($urandom);
      step(1);
    end
    checks++;
    if (werr !== 1'b1) begin
      errors++;
      $display("FAIL spur_hold: got %b want 1", werr);
    end
    idle();
  endtask

  task automatic test_flush();
    do_reset();
    iv = 1; irw = 1;
    for (int r = 0; r < NREG; r++) begin
      ird = 3'(r);
      step(1);
    end
    checks++;
    if (busy !== 8'hFF) begin
      errors++;
      $display("FAIL flush_fill: got %h want ff", busy);
    end
    fl = 1; ird = 1;
    step(1);
    checks += 2;
    if (obs_ready !== 1'b0) begin
      errors++;
      $display("FAIL flush_rdy: got %b want 0", obs_ready);
    end
    if (busy !== 8'h00) begin
      errors++;
      $display("FAIL flush_busy: got %h want 00", busy);
    end
    fl = 0;
    for (int i = 0; i < 6; i++) begin
      ird = 3'($urandom); wv = 1; wrd = 3'($urandom);
      step(1);
    end
    rst = 1; fl = 1; wv = 1; wrd = 0;
    step(1);
    checks += 3;
    if (busy !== 8'h00 || werr !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid: got busy=%h err=%b want 00 0",
               busy, werr);
    end
    if (stall !== 16'd0) begin
      errors++;
      $display("FAIL rst_stall: got %0d want 0", stall);
    end
    idle();
    step(1);
    if (obs_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_ready: got %b want 1", obs_ready);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 500; i++) begin
      rst  = ($urandom_range(0, 99) == 0);
      fl   = ($urandom_range(0, 29) == 0);
      iv   = 1'($urandom);
      irw  = ($urandom_range(0, 3) != 0);
      ird  = 3'($urandom); irs1 = 3'($urandom);
      irs2 = 3'($urandom);
      iu1  = 1'($urandom); iu2 = 1'($urandom);
      wv   = 1'($urandom); wrd = 3'($urandom);
      step(1);
    end
    idle();
  endtask

  task automatic test_stall_sat();
    do_reset();
    iv = 1; irw = 1; ird = 1;
    step(1);
    irw = 0; irs1 = 1; iu1 = 1;
    for (int i = 0; i < 69999; i++) step(0);
    step(1);
    checks++;
    if (stall !== 16'hFFFF) begin
      errors++;
      $display("FAIL stall_sat: got %h want ffff", stall);
    end
    idle();
  endtask

  initial begin
    idle();
    foreach (mc[r]) mc[r] = 0;
    merr = 0;
    mstall = 0;
    test_reset();
    test_raw();
    test_waw();
    test_simul();
    test_spurious();
    test_flush();
    test_random();
    test_stall_sat();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reg_scoreboard.md
REG_SCOREBOARD -- requirements
Module: reg_scoreboard

Interface
REQ-001 SHALL have parameter REG_W, default 3, meaning register-address width.
REQ-002 SHALL have parameter CNT_W, default 2, meaning the width of each per-register pending-write counter; counter maximum CMAX = 2^CNT_W-1.
REQ-003 SHALL have port clk  in  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-005 SHALL have port issue_valid  in  1  an instruction is presented for issue.
REQ-006 SHALL have port issue_rw  in  1  the presented instruction writes a register.
REQ-007 SHALL have ports issue_rd, issue_rs1, issue_rs2  in  REG_W each  destination and source register addresses.
REQ-008 SHALL have ports issue_rs1_used, issue_rs2_used  in  1 each  the corresponding source is actually read.
REQ-009 SHALL have port issue_ready  out  1  the presented instruction may issue this cycle.
REQ-010 SHALL have ports fwd_rs1, fwd_rs2  out  1 each  the source takes its value from this cycle's writeback bus.
REQ-011 SHALL have ports wb_valid  in  1  and  wb_rd  in  REG_W  a register write completes this cycle.
REQ-012 SHALL have port flush  in  1  discard all pending-write tracking.
REQ-013 SHALL have port busy  out  2^REG_W  bit r set when counter r is non-zero (registered view).
REQ-014 SHALL have port wb_err  out  1  sticky flag: a writeback arrived for a register with counter 0.
REQ-015 SHALL have port stall_cycles  out  16  saturating count of cycles with issue_valid=1 and issue_ready=0.

Function
REQ-016 SHALL keep one CNT_W-bit pending-write counter per register, cnt[r].
REQ-017 SHALL define issue_fire = issue_valid & issue_ready.
REQ-018 SHALL define wb_hit(x) = wb_valid & (wb_rd==x); last(x) = wb_hit(x) & (cnt[x]==1).
REQ-019 SHALL define raw1 = issue_rs1_used & (cnt[rs1]!=0) & ~last(rs1); raw2 is defined the same way for rs2.
REQ-020 SHALL define waw = issue_rw & (cnt[rd]==CMAX) & ~wb_hit(rd).
REQ-021 SHALL drive issue_ready = ~(raw1|raw2|waw) & ~flush combinationally, with zero-cycle latency.
REQ-022 SHALL drive fwd_rs1 = issue_rs1_used & last(rs1) and fwd_rs2 = issue_rs2_used & last(rs2), independent of issue_valid.
REQ-023 SHALL update cnt[r] each cycle by +1 if (issue_fire & issue_rw & rd==r) and -1 if (wb_hit(r) & cnt[r]!=0), so that a simultaneous increment and decrement leaves cnt[r] unchanged.
REQ-024 SHALL ignore a writeback to a register whose counter is 0 and set wb_err, which holds until rst.
REQ-025 SHALL, when flush=1, load all counters with 0 on the next edge; an issue or writeback in the same cycle SHALL have no effect on the counters.
REQ-026 SHALL register busy from the next-state counters, so busy reflects the counters after the edge.
REQ-027 SHALL increment stall_cycles on each stalled cycle and saturate at 16'hFFFF without wrapping.
REQ-028 SHALL treat rd==rs1 or rd==rs2 within one instruction using the pre-issue counters only.

Reset
REQ-029 SHALL, on a rst=1 edge, clear all counters, busy, wb_err and stall_cycles to 0; rst SHALL override flush, issue and writeback in the same cycle.
REQ-030 SHALL drive issue_ready=1 and fwd_*=0 in the cycle after reset when no writeback is presented.

Structure
REQ-031 SHALL take REG_W, CNT_W and CMAX from the shared CPU pipeline package, alongside the existing pipeline register-address width.
REQ-032 SHALL implement each counter as the sub-module reg_pend_cnt (inc, dec, clr; outputs count and nz), instantiated 2^REG_W times.

Verification
REQ-033 SHALL cover RAW stall: issue rw rd=3; next cycle issue rs1=3 used -> issue_ready=0, stall_cycles=1; then wb rd=3 -> issue_ready=1, fwd_rs1=1, busy[3] clears after the edge.
REQ-034 SHALL cover WAW saturation: three writes to rd=5 with no wb -> cnt=3; fourth write -> issue_ready=0; same cycle wb rd=5 -> issue_ready=1 and cnt stays 3.
REQ-035 SHALL cover simultaneous issue and wb on the same rd=2 with cnt=1 -> cnt stays 1 and busy[2] stays 1.
REQ-036 SHALL cover spurious wb: wb rd=7 with cnt 0 -> wb_err=1, counters unchanged, flag held through subsequent traffic.
REQ-037 SHALL cover flush: busy=8'hFF, assert flush with a concurrent issue -> issue_ready=0 and busy=0 after the edge; rst mid-stream -> all outputs at their reset values.
REQ-038 SHALL cover the stall counter: hold a stalled issue for 70000 cycles -> stall_cycles=16'hFFFF.
